// File: rtl/flow_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flow_mem_pkg
//  Description : Shared defaults, state encoding and width-clamp helper for
//                the flow-table memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package flow_mem_pkg;

    // Default geometry of the flow table
    localparam int unsigned c_data_bytes_dflt  = 8;
    localparam int unsigned c_depth_bytes_dflt = 4096;

    // Width of the byte-count field on the access port
    localparam int unsigned c_width_w = 4;

    // Controller states, explicitly encoded
    typedef enum logic [0:0] {
        STATE_CLEAR = 1'b0,
        STATE_READY = 1'b1
    } state_t;

    // Requests wider than one access word are trimmed to the word size
    function automatic logic [c_width_w-1:0] clamp_width(
        input logic [c_width_w-1:0] width,
        input int unsigned          max_bytes
    );
        logic [c_width_w-1:0] max_w;
        max_w = c_width_w'(max_bytes);
        return (width > max_w) ? max_w : width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flow_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : flow_mem_if
//  Description : Pipeline access port and host byte-load port of the
//                flow-table memory. The master modport is the requester side,
//                the slave modport is the memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface flow_mem_if
    import flow_mem_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = c_data_bytes_dflt,
    parameter int unsigned DEPTH_BYTES = c_depth_bytes_dflt
);
    localparam int unsigned c_addr_bus = $clog2(DEPTH_BYTES);
    localparam int unsigned c_data_bus = 8 * DATA_BYTES;

    // Pipeline access port
    logic                  mem_ce_i;
    logic                  mem_we_i;
    logic [c_addr_bus-1:0] mem_addr_i;
    logic [c_width_w-1:0]  mem_width_i;
    logic [c_data_bus-1:0] mem_data_i;
    logic [c_data_bus-1:0] mem_data_o;

    // Host byte-load port
    logic                  host_req_i;
    logic [c_addr_bus-1:0] host_addr_i;
    logic [7:0]            host_data_i;
    logic                  host_ack_o;

    // Status
    logic                  init_done_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        output host_req_i, host_addr_i, host_data_i,
        input  mem_data_o, host_ack_o, init_done_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_width_i, mem_data_i,
        input  host_req_i, host_addr_i, host_data_i,
        output mem_data_o, host_ack_o, init_done_o
    );

endinterface
`default_nettype wire

// File: rtl/flow_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : flow_mem_bank
//  Description : Byte-wide single-clock RAM with one write port and one
//                registered read port. The read register holds its value
//                while no read is enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module flow_mem_bank #(
    parameter int unsigned ROWS  = 512,
    parameter int unsigned ROW_W = 9
) (
    input  wire logic             clk,
    input  wire logic             i_we,
    input  wire logic [ROW_W-1:0] i_waddr,
    input  wire logic [7:0]       i_wdata,
    input  wire logic             i_re,
    input  wire logic [ROW_W-1:0] i_raddr,
    output logic      [7:0]       o_rdata
);

    logic [7:0] r_mem [ROWS];

    // Write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, holds the last read byte when idle
    always_ff @(posedge clk) begin
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/flow_mem.sv
`default_nettype none
// ============================================================================
//  Module      : flow_mem
//  Description : Byte-addressed flow-table memory. Serves 1..DATA_BYTES byte
//                reads/writes at any alignment in one cycle (read latency 1)
//                using DATA_BYTES byte banks, plus a byte-wide host load port
//                that is served only in cycles the pipeline leaves free.
//                Build option FLOW_MEM_CLEAR_EN adds a post-reset sweep that
//                zeroes the whole array before init_done_o rises.
//                DATA_BYTES must be a power of two between 2 and 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module flow_mem
    import flow_mem_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = c_data_bytes_dflt,
    parameter int unsigned DEPTH_BYTES = c_depth_bytes_dflt
) (
    input  wire logic clk,
    input  wire logic rst,
    flow_mem_if.slave bus
);

    localparam int unsigned c_rows   = DEPTH_BYTES / DATA_BYTES;
    localparam int unsigned c_row_w  = $clog2(c_rows);
    localparam int unsigned c_bank_w = $clog2(DATA_BYTES);
    localparam int unsigned c_addr_w = $clog2(DEPTH_BYTES);

    logic                   w_ready;
    logic                   w_clearing;
    logic [c_row_w-1:0]     w_clear_row;

    logic [c_width_w-1:0]   w_width_eff;
    logic [c_bank_w-1:0]    w_start_bank;
    logic [c_row_w-1:0]     w_start_row;
    logic [c_bank_w-1:0]    w_host_bank;
    logic [c_row_w-1:0]     w_host_row;
    logic                   w_pipe_wr;
    logic                   w_pipe_rd;
    logic                   w_host_wr;

    logic [c_bank_w-1:0]    r_rd_bank;
    logic [c_width_w-1:0]   r_rd_width;
    logic [7:0]             w_bank_rd [DATA_BYTES];
    logic [8*DATA_BYTES-1:0] w_rdata;

`ifdef FLOW_MEM_CLEAR_EN
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_row_w-1:0] r_clr_row;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STATE_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep row counter, restarts from row 0 on every reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_row <= '0;
        end else if (r_state == STATE_CLEAR) begin
            r_clr_row <= r_clr_row + 1'b1;
        end
    end

    // Next state: leave CLEAR once the last row has been written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STATE_CLEAR: begin
                if (r_clr_row == c_row_w'(c_rows - 1)) begin
                    w_state_nxt = STATE_READY;
                end
            end
            default: w_state_nxt = STATE_READY;
        endcase
    end

    // State decode
    always_comb begin
        w_clearing  = (r_state == STATE_CLEAR);
        w_ready     = (r_state == STATE_READY);
        w_clear_row = r_clr_row;
    end

    assign bus.init_done_o = w_ready;
`else
    logic r_init_done;

    // Memory is usable from the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    assign w_ready         = 1'b1;
    assign w_clearing      = 1'b0;
    assign w_clear_row     = '0;
    assign bus.init_done_o = r_init_done;
`endif

    // Access decode: start bank/row of the pipeline access and host byte
    assign w_width_eff  = clamp_width(bus.mem_width_i, DATA_BYTES);
    assign w_start_bank = bus.mem_addr_i[c_bank_w-1:0];
    assign w_start_row  = bus.mem_addr_i[c_addr_w-1:c_bank_w];
    assign w_host_bank  = bus.host_addr_i[c_bank_w-1:0];
    assign w_host_row   = bus.host_addr_i[c_addr_w-1:c_bank_w];

    // Pipeline has strict priority; the host only gets cycles with ce low
    assign w_pipe_wr = !rst && w_ready && bus.mem_ce_i && bus.mem_we_i
                       && (w_width_eff != '0);
    assign w_pipe_rd = !rst && bus.mem_ce_i && !bus.mem_we_i
                       && (w_width_eff != '0);
    assign w_host_wr = !rst && w_ready && !bus.mem_ce_i && bus.host_req_i;

    assign bus.host_ack_o = w_host_wr;

    generate
        for (genvar b = 0; b < DATA_BYTES; b++) begin : g_bank
            logic [c_bank_w-1:0] w_off;
            logic [c_row_w-1:0]  w_row;
            logic                w_in;
            logic                w_we;
            logic [c_row_w-1:0]  w_waddr;
            logic [7:0]          w_wdata;

            // Byte index k of the access that lands in this bank; banks
            // below the start bank belong to the next row (mod depth)
            assign w_off   = c_bank_w'(b) - w_start_bank;
            assign w_row   = (c_bank_w'(b) < w_start_bank) ? w_start_row + 1'b1
                                                            : w_start_row;
            assign w_in    = (c_width_w'(w_off) < w_width_eff);

            assign w_we    = w_clearing || (w_pipe_wr && w_in)
                             || (w_host_wr && (w_host_bank == c_bank_w'(b)));
            assign w_waddr = w_clearing ? w_clear_row :
                             w_host_wr  ? w_host_row  : w_row;
            assign w_wdata = w_clearing ? 8'h00 :
                             w_host_wr  ? bus.host_data_i
                                        : bus.mem_data_i[{w_off, 3'b000} +: 8];

            flow_mem_bank #(
                .ROWS  (c_rows),
                .ROW_W (c_row_w)
            ) u_bank (
                .clk     (clk),
                .i_we    (w_we),
                .i_waddr (w_waddr),
                .i_wdata (w_wdata),
                .i_re    (w_pipe_rd && w_ready && w_in),
                .i_raddr (w_row),
                .o_rdata (w_bank_rd[b])
            );
        end
    endgenerate

    // Capture start bank and width of each read; a read during the sweep
    // records width zero so it returns all zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank  <= '0;
            r_rd_width <= '0;
        end else if (w_pipe_rd) begin
            r_rd_bank  <= w_start_bank;
            r_rd_width <= w_ready ? w_width_eff : '0;
        end
    end

    // Rotate bank outputs back to byte order and zero bytes past the width
    always_comb begin
        logic [c_bank_w-1:0] idx;
        w_rdata = '0;
        idx     = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            idx = r_rd_bank + c_bank_w'(k);
            if (c_width_w'(k) < r_rd_width) begin
                w_rdata[8*k +: 8] = w_bank_rd[idx];
            end
        end
    end

    assign bus.mem_data_o = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_flow_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flow_mem
//  Description : Directed self-checking bench for flow_mem (8-byte words,
//                4096 bytes). Covers reset, the optional clear sweep,
//                unaligned, row-crossing and wrapping accesses, read hold,
//                host arbitration and width clamping.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_mem;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    flow_mem_if #(.DATA_BYTES(8), .DEPTH_BYTES(4096)) bus ();

    flow_mem #(
        .DATA_BYTES  (8),
        .DEPTH_BYTES (4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle 1 ns past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_ce_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_width_i = '0;
        bus.mem_data_i  = '0;
        bus.host_req_i  = 1'b0;
        bus.host_addr_i = '0;
        bus.host_data_i = '0;
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [3:0] width,
                            input logic [63:0] data);
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_addr_i  = addr;
        bus.mem_width_i = width;
        bus.mem_data_i  = data;
        tick();
        bus.mem_ce_i    = 1'b0;
        bus.mem_we_i    = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [3:0] width,
                           output logic [63:0] data);
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = addr;
        bus.mem_width_i = width;
        tick();
        data            = bus.mem_data_o;
        bus.mem_ce_i    = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (bus.mem_data_o !== 64'h0) begin
            bad++; $display("FAIL reset_data: got %h expected %h", bus.mem_data_o, 64'h0);
        end
        total++;
        if (bus.host_ack_o !== 1'b0) begin
            bad++; $display("FAIL reset_ack: got %b expected 0", bus.host_ack_o);
        end
        total++;
        if (bus.init_done_o !== 1'b0) begin
            bad++; $display("FAIL reset_init_done: got %b expected 0", bus.init_done_o);
        end
        rst = 1'b0;
        n = 0;
        while (bus.init_done_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        total++;
`ifdef FLOW_MEM_CLEAR_EN
        if (n != 512) begin
            bad++; $display("FAIL init_latency: got %0d cycles expected 512", n);
        end
`else
        if (n != 1) begin
            bad++; $display("FAIL init_latency: got %0d cycles expected 1", n);
        end
`endif
    endtask

    task automatic test_clear_read();
`ifdef FLOW_MEM_CLEAR_EN
        logic [63:0] d;
        do_read(12'h100, 4'd8, d);
        total++;
        if (d !== 64'h0) begin
            bad++; $display("FAIL cleared_read: got %h expected %h", d, 64'h0);
        end
`endif
    endtask

    task automatic test_unaligned();
        logic [63:0] d;
        do_write(12'd3, 4'd4, 64'h00000000DDCCBBAA);
        do_read(12'd3, 4'd4, d);
        total++;
        if (d !== 64'h00000000DDCCBBAA) begin
            bad++; $display("FAIL unaligned_raw: got %h expected %h", d, 64'h00000000DDCCBBAA);
        end
        do_read(12'd4, 4'd1, d);
        total++;
        if (d !== 64'hBB) begin
            bad++; $display("FAIL unaligned_byte: got %h expected %h", d, 64'hBB);
        end
    endtask

    task automatic test_row_cross();
        logic [63:0] d;
        do_write(12'd6, 4'd8, 64'h0807060504030201);
        do_read(12'd8, 4'd2, d);
        total++;
        if (d !== 64'h0403) begin
            bad++; $display("FAIL row_cross_pair: got %h expected %h", d, 64'h0403);
        end
        do_read(12'd6, 4'd8, d);
        total++;
        if (d !== 64'h0807060504030201) begin
            bad++; $display("FAIL row_cross_full: got %h expected %h", d, 64'h0807060504030201);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        do_write(12'd4094, 4'd4, 64'h44332211);
        do_read(12'd0, 4'd2, d);
        total++;
        if (d !== 64'h4433) begin
            bad++; $display("FAIL wrap_low: got %h expected %h", d, 64'h4433);
        end
        do_read(12'd4094, 4'd4, d);
        total++;
        if (d !== 64'h44332211) begin
            bad++; $display("FAIL wrap_span: got %h expected %h", d, 64'h44332211);
        end
    endtask

    task automatic test_hold();
        logic [63:0] d;
        do_read(12'd3, 4'd2, d);
        do_write(12'd3, 4'd2, 64'h9999);
        repeat (2) tick();
        total++;
        if (bus.mem_data_o !== 64'hBBAA) begin
            bad++; $display("FAIL hold_after_write: got %h expected %h", bus.mem_data_o, 64'hBBAA);
        end
        // zero-width read is a no-op on the output register
        do_read(12'd6, 4'd0, d);
        total++;
        if (d !== 64'hBBAA) begin
            bad++; $display("FAIL hold_width0_read: got %h expected %h", d, 64'hBBAA);
        end
    endtask

    task automatic test_host();
        logic [63:0] d;
        bus.host_req_i  = 1'b1;
        bus.host_addr_i = 12'h010;
        bus.host_data_i = 8'h5A;
        bus.mem_ce_i    = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = 12'd3;
        bus.mem_width_i = 4'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.host_ack_o !== 1'b0) begin
                bad++; $display("FAIL host_blocked_%0d: got %b expected 0", i, bus.host_ack_o);
            end
            tick();
        end
        bus.mem_ce_i = 1'b0;
        #1;
        total++;
        if (bus.host_ack_o !== 1'b1) begin
            bad++; $display("FAIL host_ack_free: got %b expected 1", bus.host_ack_o);
        end
        tick();
        // request held across two more free cycles, changed after each ack
        bus.host_addr_i = 12'h011;
        bus.host_data_i = 8'h77;
        #1;
        total++;
        if (bus.host_ack_o !== 1'b1) begin
            bad++; $display("FAIL host_ack_b2b_1: got %b expected 1", bus.host_ack_o);
        end
        tick();
        bus.host_addr_i = 12'h012;
        bus.host_data_i = 8'h88;
        #1;
        total++;
        if (bus.host_ack_o !== 1'b1) begin
            bad++; $display("FAIL host_ack_b2b_2: got %b expected 1", bus.host_ack_o);
        end
        tick();
        bus.host_req_i = 1'b0;
        do_read(12'h010, 4'd1, d);
        total++;
        if (d !== 64'h5A) begin
            bad++; $display("FAIL host_byte: got %h expected %h", d, 64'h5A);
        end
        do_read(12'h010, 4'd3, d);
        total++;
        if (d !== 64'h88775A) begin
            bad++; $display("FAIL host_run: got %h expected %h", d, 64'h88775A);
        end
    endtask

    task automatic test_width_limits();
        logic [63:0] d;
        do_write(12'd8, 4'd8, 64'hA0A1A2A3A4A5A6A7);
        do_write(12'd0, 4'd8, 64'h8877665544332211);
        do_write(12'd0, 4'd0, 64'hFFFFFFFFFFFFFFFF);
        do_read(12'd0, 4'd8, d);
        total++;
        if (d !== 64'h8877665544332211) begin
            bad++; $display("FAIL width0_write: got %h expected %h", d, 64'h8877665544332211);
        end
        do_write(12'd0, 4'd12, 64'hCAFEBABEDEADBEEF);
        do_read(12'd0, 4'd8, d);
        total++;
        if (d !== 64'hCAFEBABEDEADBEEF) begin
            bad++; $display("FAIL width12_write: got %h expected %h", d, 64'hCAFEBABEDEADBEEF);
        end
        do_read(12'd8, 4'd8, d);
        total++;
        if (d !== 64'hA0A1A2A3A4A5A6A7) begin
            bad++; $display("FAIL width12_neighbour: got %h expected %h", d, 64'hA0A1A2A3A4A5A6A7);
        end
        do_read(12'd8, 4'd15, d);
        total++;
        if (d !== 64'hA0A1A2A3A4A5A6A7) begin
            bad++; $display("FAIL width15_read: got %h expected %h", d, 64'hA0A1A2A3A4A5A6A7);
        end
    endtask

    task automatic test_reset_host();
        bus.host_req_i  = 1'b1;
        bus.host_addr_i = 12'h020;
        bus.host_data_i = 8'h33;
        rst             = 1'b1;
        #1;
        total++;
        if (bus.host_ack_o !== 1'b0) begin
            bad++; $display("FAIL reset_host_ack: got %b expected 0", bus.host_ack_o);
        end
        tick();
        total++;
        if (bus.mem_data_o !== 64'h0) begin
            bad++; $display("FAIL rereset_data: got %h expected %h", bus.mem_data_o, 64'h0);
        end
        total++;
        if (bus.init_done_o !== 1'b0) begin
            bad++; $display("FAIL rereset_init_done: got %b expected 0", bus.init_done_o);
        end
        bus.host_req_i = 1'b0;
        rst            = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_clear_read();
        test_unaligned();
        test_row_cross();
        test_wrap();
        test_hold();
        test_host();
        test_width_limits();
        test_reset_host();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
